// File: rtl/calc_pkg.sv
// Shared types and key codes for the calculator controller slice.
package calc_pkg;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_EXEC = 2'd2,
        S_RES  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4
    } alu_op_t;

    localparam logic [4:0] K_ADD = 5'h10;
    localparam logic [4:0] K_MUL = 5'h11;
    localparam logic [4:0] K_AND = 5'h12;
    localparam logic [4:0] K_EXE = 5'h13;
    localparam logic [4:0] K_SUB = 5'h14;
    localparam logic [4:0] K_OR  = 5'h15;
    localparam logic [4:0] K_CE  = 5'h16;
    localparam logic [4:0] K_CLR = 5'h17;

    function automatic logic is_op_key(input logic [4:0] k);
        return (k == K_ADD) || (k == K_SUB) || (k == K_MUL) ||
               (k == K_AND) || (k == K_OR);
    endfunction

    function automatic alu_op_t key_to_op(input logic [4:0] k);
        case (k)
            K_SUB:   return OP_SUB;
            K_MUL:   return OP_MUL;
            K_AND:   return OP_AND;
            K_OR:    return OP_OR;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/calc_ctrl_if.sv
// Keypad and ALU handshake bundle; master is the controller, slave the keypad/ALU side.
interface calc_ctrl_if #(parameter int NDIG = 4);
    import calc_pkg::*;

    logic                key_valid;
    logic [4:0]          key_val;
    logic                alu_start;
    logic [4*NDIG-1:0]   alu_a;
    logic [4*NDIG-1:0]   alu_b;
    alu_op_t             alu_op;
    logic                alu_done;
    logic [4*NDIG-1:0]   alu_result;

    modport master (
        input  key_valid, key_val, alu_done, alu_result,
        output alu_start, alu_a, alu_b, alu_op
    );

    modport slave (
        output key_valid, key_val, alu_done, alu_result,
        input  alu_start, alu_a, alu_b, alu_op
    );

endinterface

// File: rtl/operand_shreg.sv
// One operand register: BCD/hex digit shift-in, whole-value load, digit count and full flag.
module operand_shreg #(
    parameter int NDIG = 4,
    parameter int CW   = $clog2(NDIG + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [4*NDIG-1:0] load_val,
    input  logic [CW-1:0]     load_cnt,
    input  logic              shift,
    input  logic [3:0]        digit,
    output logic [4*NDIG-1:0] val,
    output logic [CW-1:0]     cnt,
    output logic              full
);

    localparam int W = 4 * NDIG;

    assign full = (cnt == CW'(NDIG));

    // Clear wins over load, load over shift; the caller gates shift with full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val <= '0;
            cnt <= '0;
        end else if (clr) begin
            val <= '0;
            cnt <= '0;
        end else if (load) begin
            val <= load_val;
            cnt <= load_cnt;
        end else if (shift) begin
            val <= (val << 4) | W'(digit);
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/calc_ctrl.sv
// Calculator key-entry controller: builds operands from keypresses, drives the ALU, tracks results.
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int NDIG = 4,
    parameter int TMO  = 255
) (
    input  logic              clk,
    input  logic              rst,
    calc_ctrl_if.master       bus,
    input  logic              dec_mode,
    output logic              restriction,
    output logic [4*NDIG-1:0] disp_val,
    output logic [1:0]        state,
    output logic              err
);

    localparam int W  = 4 * NDIG;
    localparam int CW = $clog2(NDIG + 1);
    localparam int TW = $clog2(TMO + 1);

    state_t          st;
    alu_op_t         op;
    logic            start_r;
    logic            primed;
    logic [TW-1:0]   tmo_cnt;

    logic            key_dig, dig_ok, key_op, key_exe, key_ce, key_clr, mode_chg, tmo_hit;
    logic            a_clr, a_load, a_shift, b_clr, b_shift;
    logic [W-1:0]    a_load_val, a_val, b_val;
    logic [CW-1:0]   a_load_cnt, a_cnt_unused, b_cnt;
    logic            a_full, b_full;

    assign key_dig  = bus.key_valid && !bus.key_val[4];
    assign dig_ok   = key_dig && !(dec_mode && (bus.key_val[3:0] > 4'd9));
    assign key_op   = bus.key_valid && is_op_key(bus.key_val);
    assign key_exe  = bus.key_valid && (bus.key_val == K_EXE);
    assign key_ce   = bus.key_valid && (bus.key_val == K_CE);
    assign key_clr  = bus.key_valid && (bus.key_val == K_CLR);
    assign mode_chg = primed && (restriction != dec_mode);
    assign tmo_hit  = (tmo_cnt == TW'(TMO - 1));

    // Operand register controls; a mode change or timeout wipes both operands.
    always_comb begin
        a_clr      = 1'b0;
        a_load     = 1'b0;
        a_load_val = '0;
        a_load_cnt = '0;
        a_shift    = 1'b0;
        b_clr      = 1'b0;
        b_shift    = 1'b0;
        if (mode_chg) begin
            a_clr = 1'b1;
            b_clr = 1'b1;
        end else begin
            case (st)
                S_A: begin
                    a_shift = dig_ok && !a_full;
                    a_clr   = key_ce || key_clr;
                    b_clr   = key_op || key_clr;
                end
                S_B: begin
                    b_shift = dig_ok && !b_full;
                    a_clr   = key_clr;
                    b_clr   = key_ce || key_clr;
                end
                S_EXEC: begin
                    if (bus.alu_done) begin
                        a_load     = 1'b1;
                        a_load_val = bus.alu_result;
                        a_load_cnt = CW'(NDIG);
                    end else if (tmo_hit) begin
                        a_clr = 1'b1;
                        b_clr = 1'b1;
                    end
                end
                S_RES: begin
                    a_load     = dig_ok;
                    a_load_val = W'(bus.key_val[3:0]);
                    a_load_cnt = CW'(1);
                    a_clr      = key_ce || key_clr;
                    b_clr      = key_op || key_clr;
                end
                default: ;
            endcase
        end
    end

    operand_shreg #(.NDIG(NDIG)) u_a (
        .clk(clk), .rst(rst), .clr(a_clr), .load(a_load), .load_val(a_load_val),
        .load_cnt(a_load_cnt), .shift(a_shift), .digit(bus.key_val[3:0]),
        .val(a_val), .cnt(a_cnt_unused), .full(a_full)
    );

    operand_shreg #(.NDIG(NDIG)) u_b (
        .clk(clk), .rst(rst), .clr(b_clr), .load(1'b0), .load_val('0),
        .load_cnt('0), .shift(b_shift), .digit(bus.key_val[3:0]),
        .val(b_val), .cnt(b_cnt), .full(b_full)
    );

    // Main FSM; the first cycle out of reset only syncs restriction without a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= S_A;
            op          <= OP_ADD;
            start_r     <= 1'b0;
            err         <= 1'b0;
            restriction <= 1'b0;
            primed      <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            restriction <= dec_mode;
            primed      <= 1'b1;
            start_r     <= 1'b0;
            if (bus.key_valid)
                err <= 1'b0;
            if (mode_chg) begin
                st      <= S_A;
                op      <= OP_ADD;
                tmo_cnt <= '0;
            end else begin
                case (st)
                    S_A: begin
                        if (key_op) begin
                            op <= key_to_op(bus.key_val);
                            st <= S_B;
                        end else if (key_clr) begin
                            op <= OP_ADD;
                        end
                    end
                    S_B: begin
                        if (key_clr) begin
                            op <= OP_ADD;
                            st <= S_A;
                        end else if (key_op && b_cnt == '0) begin
                            op <= key_to_op(bus.key_val);
                        end else if (key_exe && b_cnt != '0) begin
                            start_r <= 1'b1;
                            tmo_cnt <= '0;
                            st      <= S_EXEC;
                        end
                    end
                    S_EXEC: begin
                        if (bus.alu_done) begin
                            tmo_cnt <= '0;
                            st      <= S_RES;
                        end else if (tmo_hit) begin
                            err     <= 1'b1;
                            op      <= OP_ADD;
                            tmo_cnt <= '0;
                            st      <= S_A;
                        end else begin
                            tmo_cnt <= tmo_cnt + TW'(1);
                        end
                    end
                    S_RES: begin
                        if (key_clr) begin
                            op <= OP_ADD;
                            st <= S_A;
                        end else if (key_op) begin
                            op <= key_to_op(bus.key_val);
                            st <= S_B;
                        end else if (dig_ok || key_ce) begin
                            st <= S_A;
                        end
                    end
                    default: st <= S_A;
                endcase
            end
        end
    end

    assign bus.alu_start = start_r;
    assign bus.alu_a     = a_val;
    assign bus.alu_b     = b_val;
    assign bus.alu_op    = op;
    assign state         = st;
    assign disp_val      = (st == S_B && b_cnt != '0) ? b_val : a_val;

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed-vector bench for calc_ctrl; the bench plays both keypad and ALU.
module tb_calc_ctrl;

    localparam int NDIG = 4;
    localparam int TMO  = 255;

    logic        clk;
    logic        rst;
    logic        dec_mode;
    logic        restriction;
    logic [15:0] disp_val;
    logic [1:0]  state;
    logic        err;

    int n_cmp;
    int n_bad;
    int tmo_seen_at;

    calc_ctrl_if #(.NDIG(NDIG)) bus ();

    calc_ctrl #(.NDIG(NDIG), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .bus(bus), .dec_mode(dec_mode),
        .restriction(restriction), .disp_val(disp_val), .state(state), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One keypress; returns #1 after the edge that sampled the key.
    task automatic applyStimulus(input logic [4:0] k);
        @(posedge clk);
        #1;
        bus.key_valid = 1'b1;
        bus.key_val   = k;
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
        bus.key_val   = 5'h1F;
    endtask

    task automatic alu_reply(input logic [15:0] res);
        @(posedge clk);
        #1;
        bus.alu_done   = 1'b1;
        bus.alu_result = res;
        @(posedge clk);
        #1;
        bus.alu_done   = 1'b0;
        bus.alu_result = 16'hDEAD;
    endtask

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        tmo_seen_at    = 0;
        rst            = 1'b1;
        dec_mode       = 1'b0;
        bus.key_valid  = 1'b0;
        bus.key_val    = 5'h1F;
        bus.alu_done   = 1'b0;
        bus.alu_result = 16'hDEAD;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_state", 32'(state), 0);
        checkOutput("rst_disp", 32'(disp_val), 0);
        checkOutput("rst_err", 32'(err), 0);
        checkOutput("rst_start", 32'(bus.alu_start), 0);
        checkOutput("rst_op", 32'(bus.alu_op), 0);
        checkOutput("rst_restr", 32'(restriction), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Basic add: 12 + 3
        applyStimulus(5'h01);
        applyStimulus(5'h02);
        checkOutput("a_12", 32'(disp_val), 32'h12);
        applyStimulus(5'h10);
        checkOutput("op_to_b", 32'(state), 1);
        checkOutput("disp_a_in_b", 32'(disp_val), 32'h12);
        applyStimulus(5'h03);
        checkOutput("disp_b", 32'(disp_val), 32'h3);
        applyStimulus(5'h13);
        checkOutput("start_hi", 32'(bus.alu_start), 1);
        checkOutput("exe_a", 32'(bus.alu_a), 32'h12);
        checkOutput("exe_b", 32'(bus.alu_b), 32'h3);
        checkOutput("exe_op", 32'(bus.alu_op), 0);
        checkOutput("exec_state", 32'(state), 2);
        @(posedge clk);
        #1;
        checkOutput("start_lo", 32'(bus.alu_start), 0);
        alu_reply(16'h0015);
        checkOutput("res_disp", 32'(disp_val), 32'h15);
        checkOutput("res_state", 32'(state), 3);

        // Chaining from result: or with 1
        applyStimulus(5'h15);
        checkOutput("chain_state", 32'(state), 1);
        applyStimulus(5'h01);
        applyStimulus(5'h13);
        checkOutput("chain_a", 32'(bus.alu_a), 32'h15);
        checkOutput("chain_b", 32'(bus.alu_b), 32'h1);
        checkOutput("chain_op", 32'(bus.alu_op), 4);
        alu_reply(16'h0015);
        applyStimulus(5'h17);
        checkOutput("clr_state", 32'(state), 0);
        checkOutput("clr_disp", 32'(disp_val), 0);
        checkOutput("clr_op", 32'(bus.alu_op), 0);

        // Digit limit and CE
        applyStimulus(5'h01);
        applyStimulus(5'h02);
        applyStimulus(5'h03);
        applyStimulus(5'h04);
        applyStimulus(5'h05);
        checkOutput("a_full", 32'(disp_val), 32'h1234);
        applyStimulus(5'h16);
        checkOutput("ce_a", 32'(disp_val), 0);

        // Op replacement only while B empty
        applyStimulus(5'h07);
        applyStimulus(5'h10);
        applyStimulus(5'h14);
        checkOutput("op_replaced", 32'(bus.alu_op), 1);
        applyStimulus(5'h02);
        applyStimulus(5'h11);
        checkOutput("op_kept", 32'(bus.alu_op), 1);
        applyStimulus(5'h13);
        checkOutput("sub_a", 32'(bus.alu_a), 32'h7);
        checkOutput("sub_b", 32'(bus.alu_b), 32'h2);
        applyStimulus(5'h17);
        checkOutput("exec_ignores_clr", 32'(state), 2);
        alu_reply(16'h0005);
        checkOutput("sub_res", 32'(disp_val), 32'h5);

        // Digit in result starts fresh; EXE and invalid keys ignored in S_A
        applyStimulus(5'h04);
        checkOutput("res_digit_state", 32'(state), 0);
        checkOutput("res_digit_disp", 32'(disp_val), 32'h4);
        applyStimulus(5'h13);
        applyStimulus(5'h1F);
        checkOutput("ignored_keys", {30'(disp_val), state}, {30'h4, 2'd0});

        // Timeout
        applyStimulus(5'h10);
        applyStimulus(5'h01);
        applyStimulus(5'h13);
        for (int i = 1; i <= TMO + 20 && tmo_seen_at == 0; i++) begin
            @(posedge clk);
            #1;
            if (err) tmo_seen_at = i;
        end
        checkOutput("tmo_cycles", 32'(tmo_seen_at), TMO);
        checkOutput("tmo_state", 32'(state), 0);
        checkOutput("tmo_disp", 32'(disp_val), 0);
        applyStimulus(5'h05);
        checkOutput("err_cleared", 32'(err), 0);
        checkOutput("after_err_a", 32'(disp_val), 32'h5);

        // Decimal mode: mode change clears, hex digits rejected, abort of S_EXEC
        @(posedge clk);
        #1;
        dec_mode = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("restr_dec", 32'(restriction), 1);
        checkOutput("mode_clr", 32'(disp_val), 0);
        applyStimulus(5'h03);
        applyStimulus(5'h0A);
        checkOutput("dec_reject", 32'(disp_val), 32'h3);
        applyStimulus(5'h10);
        applyStimulus(5'h02);
        applyStimulus(5'h13);
        checkOutput("dec_exec", 32'(state), 2);
        dec_mode = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_state", 32'(state), 0);
        alu_reply(16'h0099);
        checkOutput("late_done_state", 32'(state), 0);
        checkOutput("late_done_disp", 32'(disp_val), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
